ecpri_mem_arb: RTL

ECPRI_MEM_ARB -- requirements
Module: ecpri_mem_arb

---
 rtl/ecpri_mem_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ecpri_mem_arb.sv
// Three-requester arbiter for a shared single-port memory: round-robin with an
// exclusive bounded lock, registered issue, and a pipelined read-return path.
module ecpri_mem_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  input  logic                  we_0,
  input  logic                  we_1,
  input  logic                  we_2,
  input  logic                  oe_0,
  input  logic                  oe_1,
  input  logic                  oe_2,
  input  logic                  lock_0,
  input  logic                  lock_1,
  input  logic                  lock_2,
  output logic                  gnt_0,
  output logic                  gnt_1,
  output logic                  gnt_2,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic [DATA_WIDTH-1:0] rdata_2,
  output logic                  rvalid_0,
  output logic                  rvalid_1,
  output logic                  rvalid_2,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  typedef enum logic {StUnlocked, StLocked} state_e;

  logic [2:0][ADDR_WIDTH-1:0] addr;
  logic [2:0][DATA_WIDTH-1:0] data;
  logic [2:0]                 we, oe, lock, req;

  assign addr = {addr_2, addr_1, addr_0};
  assign data = {data_2, data_1, data_0};
  assign we   = {we_2, we_1, we_0};
  assign oe   = {oe_2, oe_1, oe_0};
  assign lock = {lock_2, lock_1, lock_0};
  assign req  = we | oe;

  state_e                     state_q, state_d;
  logic [1:0]                 owner_q, owner_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [1:0]                 last_q, last_d;
  logic [2:0]                 gnt_q;
  logic [1:0]                 gnt_id_q;
  logic [ADDR_WIDTH-1:0]      mem_addr_q;
  logic [DATA_WIDTH-1:0]      mem_wdata_q;
  logic                       mem_we_q, mem_oe_q;
  logic                       rd_pend_q;
  logic [1:0]                 rd_id_q;
  logic [2:0]                 rvalid_q;
  logic [2:0][DATA_WIDTH-1:0] rdata_q;

  logic       win, lock_hit;
  logic [1:0] win_id, cand;
  logic [2:0] elig;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win      = 1'b0;
    win_id   = 2'd0;
    elig     = 3'b000;
    cand     = last_q;
    lock_hit = (state_q == StLocked) && (cnt_q == CntW'(LOCK_MAX));
    if ((state_q == StLocked) && !lock_hit && lock[owner_q]) begin
      // Owner keeps the memory; an idle owner simply stalls everyone.
      if (req[owner_q]) begin
        win    = 1'b1;
        win_id = owner_q;
        cnt_d  = cnt_q + CntW'(1);
      end
    end else begin
      // A requester already showing gnt is still holding the serviced request.
      elig = req & ~gnt_q;
      if (lock_hit) elig[owner_q] = 1'b0;
      state_d = StUnlocked;
      cnt_d   = '0;
      for (int k = 0; k < 3; k++) begin
        cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        if (!win && elig[cand]) begin
          win    = 1'b1;
          win_id = cand;
        end
      end
      if (win && lock[win_id]) begin
        state_d = StLocked;
        owner_d = win_id;
        cnt_d   = CntW'(1);
      end
    end
    if (win) last_d = win_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StUnlocked;
      owner_q     <= 2'd0;
      cnt_q       <= '0;
      last_q      <= 2'd2;
      gnt_q       <= 3'b000;
      gnt_id_q    <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= 2'd0;
      rvalid_q    <= 3'b000;
      rdata_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= win ? (3'b001 << win_id) : 3'b000;
      mem_we_q <= win & we[win_id];
      mem_oe_q <= win & oe[win_id] & ~we[win_id];
      if (win) begin
        gnt_id_q    <= win_id;
        mem_addr_q  <= addr[win_id];
        mem_wdata_q <= data[win_id];
      end
      // Memory answers one cycle after mem_oe; tag travels alongside.
      rd_pend_q <= mem_oe_q;
      rd_id_q   <= gnt_id_q;
      rvalid_q  <= rd_pend_q ? (3'b001 << rd_id_q) : 3'b000;
      if (rd_pend_q) rdata_q[rd_id_q] <= mem_rdata;
    end
  end

  assign gnt_0     = gnt_q[0];
  assign gnt_1     = gnt_q[1];
  assign gnt_2     = gnt_q[2];
  assign rvalid_0  = rvalid_q[0];
  assign rvalid_1  = rvalid_q[1];
  assign rvalid_2  = rvalid_q[2];
  assign rdata_0   = rdata_q[0];
  assign rdata_1   = rdata_q[1];
  assign rdata_2   = rdata_q[2];
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;

endmodule
